// File: rtl/sync_fifo_lvl.sv
// Synchronous byte FIFO with occupancy count, programmable interrupt level,
// almost-full/almost-empty flags, synchronous flush and sticky error flags.
// Shared by the UART TX and RX paths. Read data is registered and qualified
// by a one-cycle rd_valid strobe.
module sync_fifo_lvl #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH:0]   trig_level,
    output logic                  level_int,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE     = CW'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_VAL   = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_VAL   = CW'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_VAL  = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_set;
    logic                  udf_set;

    assign wr_idx = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr[ADDR_WIDTH-1:0];

    // The extra pointer bit makes full (difference = depth) distinct from empty.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_VAL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_VAL);
    assign almost_empty = (count <= AEMPTY_VAL);
    assign level_int    = (trig_level != '0) && (count >= trig_level);

    // A read on a full FIFO frees a slot, so a simultaneous write is still taken.
    // There is no bypass: a write into an empty FIFO cannot satisfy a same-cycle read.
    assign rd_acc  = rd && !empty;
    assign wr_acc  = wr && (!full || rd_acc);
    assign ovf_set = !flush && wr && full && !rd_acc;
    assign udf_set = !flush && rd && empty;

    // Storage is not reset; writes are suppressed while reset or flush is active.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Pointers, registered read port and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rd_valid <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_acc) begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    rd_data <= mem[rd_idx];
                end
                rd_valid <= rd_acc;
            end
            overflow  <= ovf_set || (overflow && !err_clr);
            underflow <= udf_set || (underflow && !err_clr);
        end
    end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed self-checking bench for sync_fifo_lvl with hand-computed expectations.
module tb_sync_fifo_lvl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic       rd;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] count;
    logic [4:0] trig_level;
    logic       level_int;
    logic       err_clr;
    logic       overflow;
    logic       underflow;

    int vectors;
    int miscompares;

    sync_fifo_lvl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr           (wr),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .rd           (rd),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .trig_level   (trig_level),
        .level_int    (level_int),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then land 1 unit after the rising edge for checks.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                                 input logic f, input logic ec, input logic rs);
        wr      = w;
        wr_data = d;
        rd      = r;
        flush   = f;
        err_clr = ec;
        rst     = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doWrite(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doRead();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        trig_level  = 5'd0;

        // ---------------- reset state ----------------
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_aempty", 32'(almost_empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_lvl", 32'(level_int), 32'd0);
        checkOutput("rst_rdv", 32'(rd_valid), 32'd0);
        checkOutput("rst_rdata", 32'(rd_data), 32'h00);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_udf", 32'(underflow), 32'd0);

        // ---------------- test 1: 15 bytes in, 15 out ----------------
        for (int i = 0; i < 15; i++) begin
            doWrite(8'(8'h11 + i));
            checkOutput("t1_wcount", 32'(count), 32'(i + 1));
            checkOutput("t1_afull", 32'(almost_full), 32'((i + 1) >= 14));
            checkOutput("t1_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
            checkOutput("t1_full", 32'(full), 32'd0);
        end
        for (int i = 0; i < 15; i++) begin
            doRead();
            checkOutput("t1_rdv", 32'(rd_valid), 32'd1);
            checkOutput("t1_rdata", 32'(rd_data), 32'(8'h11 + i));
            checkOutput("t1_rcount", 32'(count), 32'(14 - i));
        end
        doIdle();
        checkOutput("t1_idle_rdv", 32'(rd_valid), 32'd0);
        checkOutput("t1_hold_rdata", 32'(rd_data), 32'h1F);
        checkOutput("t1_empty", 32'(empty), 32'd1);

        // ---------------- test 2: full with simultaneous write+read ----------------
        for (int i = 0; i < 16; i++) doWrite(8'(8'h20 + i));
        checkOutput("t2_count16", 32'(count), 32'd16);
        checkOutput("t2_full", 32'(full), 32'd1);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_wr_rd_count", 32'(count), 32'd16);
        checkOutput("t2_no_ovf", 32'(overflow), 32'd0);
        checkOutput("t2_head_rdv", 32'(rd_valid), 32'd1);
        checkOutput("t2_head", 32'(rd_data), 32'h20);
        for (int i = 0; i < 16; i++) begin
            doRead();
            checkOutput("t2_drain", 32'(rd_data), (i < 15) ? 32'(8'h21 + i) : 32'hAA);
        end
        checkOutput("t2_empty", 32'(empty), 32'd1);

        // ---------------- test 3: overflow and err_clr ----------------
        for (int i = 0; i < 16; i++) doWrite(8'(8'h30 + i));
        doWrite(8'hBB);
        checkOutput("t3_ovf", 32'(overflow), 32'd1);
        checkOutput("t3_count", 32'(count), 32'd16);
        applyStimulus(1'b1, 8'hBC, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_err_wins", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            doRead();
            checkOutput("t3_data", 32'(rd_data), 32'(8'h30 + i));
        end
        checkOutput("t3_empty", 32'(empty), 32'd1);

        // ---------------- test 4: underflow, no bypass ----------------
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_udf", 32'(underflow), 32'd1);
        checkOutput("t4_rdv", 32'(rd_valid), 32'd0);
        checkOutput("t4_count", 32'(count), 32'd1);
        doRead();
        checkOutput("t4_rdv2", 32'(rd_valid), 32'd1);
        checkOutput("t4_data", 32'(rd_data), 32'h5A);
        checkOutput("t4_sticky", 32'(underflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_clr", 32'(underflow), 32'd0);

        // ---------------- test 5: trigger level ----------------
        trig_level = 5'd4;
        for (int i = 0; i < 3; i++) doWrite(8'(8'h60 + i));
        checkOutput("t5_lvl_3", 32'(level_int), 32'd0);
        doWrite(8'h63);
        checkOutput("t5_lvl_4", 32'(level_int), 32'd1);
        doRead();
        checkOutput("t5_lvl_after_rd", 32'(level_int), 32'd0);
        trig_level = 5'd3;
        #1;
        checkOutput("t5_lvl_eq", 32'(level_int), 32'd1);
        trig_level = 5'd0;
        for (int i = 0; i < 13; i++) doWrite(8'(8'h64 + i));
        checkOutput("t5_count16", 32'(count), 32'd16);
        checkOutput("t5_lvl_dis", 32'(level_int), 32'd0);
        trig_level = 5'd17;
        #1;
        checkOutput("t5_lvl_over", 32'(level_int), 32'd0);
        trig_level = 5'd16;
        #1;
        checkOutput("t5_lvl_16", 32'(level_int), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_flush_count", 32'(count), 32'd0);
        checkOutput("t5_flush_lvl", 32'(level_int), 32'd0);

        // ---------------- test 6: wrap with interleaved reads, flush, reset ----------------
        trig_level = 5'd1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(8'h70 + i), (i % 2) == 1, 1'b0, 1'b0, 1'b0);
            checkOutput("t6_count", 32'(count), 32'(i / 2 + 1));
            if ((i % 2) == 1) checkOutput("t6_rdata", 32'(rd_data), 32'(8'h70 + (i - 1) / 2));
        end
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_fl_count", 32'(count), 32'd0);
        checkOutput("t6_fl_empty", 32'(empty), 32'd1);
        checkOutput("t6_fl_rdv", 32'(rd_valid), 32'd0);
        checkOutput("t6_fl_ovf", 32'(overflow), 32'd0);
        checkOutput("t6_fl_udf", 32'(underflow), 32'd0);
        checkOutput("t6_fl_hold", 32'(rd_data), 32'h79);
        doRead();
        checkOutput("t6_udf_set", 32'(underflow), 32'd1);
        doWrite(8'h90);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_fl_keeps_udf", 32'(underflow), 32'd1);
        for (int i = 0; i < 5; i++) doWrite(8'(8'hA0 + i));
        checkOutput("t6_pre_rst_lvl", 32'(level_int), 32'd1);
        doRead();
        applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_rst_count", 32'(count), 32'd0);
        checkOutput("t6_rst_empty", 32'(empty), 32'd1);
        checkOutput("t6_rst_rdv", 32'(rd_valid), 32'd0);
        checkOutput("t6_rst_rdata", 32'(rd_data), 32'h00);
        checkOutput("t6_rst_udf", 32'(underflow), 32'd0);
        checkOutput("t6_rst_lvl", 32'(level_int), 32'd0);
        doWrite(8'hD1);
        doRead();
        checkOutput("t6_post_rst", 32'(rd_data), 32'hD1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
